// File: rtl/sccb_config_seq.sv
// sccb_config_seq: walks an external {reg_addr, value} table once per start
// and issues one 3-phase SCCB write (device ID, register, data) per entry.
// Sentinel words end the table (16'hFFFF) or insert a fixed delay (16'hFFF0).
module sccb_config_seq #(
  parameter int unsigned CLK_DIV      = 250,
  parameter logic [7:0]  DEV_ID       = 8'h42,
  parameter int unsigned DELAY_CYCLES = 1_000_000,
  parameter int unsigned ROM_AW       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sioc,
  output logic              siod_out,
  output logic              siod_oe,
  output logic              busy,
  output logic              done
);

  localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  localparam logic [QW-1:0] QLAST    = QW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DLAST    = DW'(DELAY_CYCLES - 1);
  localparam logic [15:0]   END_WORD = 16'hFFFF;
  localparam logic [15:0]   DLY_WORD = 16'hFFF0;

  // Bus levels are carried as {sioc, siod_out, siod_oe}.
  localparam logic [2:0] BUS_IDLE  = 3'b111;
  localparam logic [2:0] BUS_START = 3'b101;
  localparam logic [2:0] BUS_LOW   = 3'b001;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_START,
    S_BYTE,
    S_STOP,
    S_GAP,
    S_DELAY,
    S_FINISH
  } state_t;

  state_t        state;
  logic [QW-1:0] qcnt;
  logic [1:0]    quarter;
  logic [3:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [DW-1:0] dly_cnt;
  logic [7:0]    reg_q;
  logic [7:0]    val_q;

  logic          tick_c;
  logic          last_entry_c;
  logic [7:0]    cur_byte_c;

  // Byte selected for a given phase of the 3-phase write.
  function automatic logic [7:0] byte_of(input logic [1:0] idx,
                                         input logic [7:0] r,
                                         input logic [7:0] v);
    logic [7:0] b;
    b = DEV_ID;
    case (idx)
      2'd1:    b = r;
      2'd2:    b = v;
      default: b = DEV_ID;
    endcase
    return b;
  endfunction

  // Bus levels for a given state/quarter/bit, applied on entry to that quarter.
  function automatic logic [2:0] bus_level(input state_t     st,
                                           input logic [1:0] q,
                                           input logic [3:0] bi,
                                           input logic [7:0] bv);
    logic [2:0] lv;
    lv = BUS_IDLE;
    case (st)
      S_START: lv = (q == 2'd0) ? BUS_START : BUS_LOW;
      S_BYTE: begin
        if (bi == 4'd8) begin
          // ACK slot: release SIOD, keep clocking.
          lv = {q[1], 1'b1, 1'b0};
        end else begin
          lv = {q[1], bv[3'(4'd7 - bi)], 1'b1};
        end
      end
      S_STOP: begin
        case (q)
          2'd0:    lv = BUS_LOW;
          2'd1:    lv = BUS_START;
          default: lv = BUS_IDLE;
        endcase
      end
      default: lv = BUS_IDLE;
    endcase
    return lv;
  endfunction

  // Quarter tick, end-of-table detection and current byte under transmission.
  assign tick_c       = (qcnt == QLAST);
  assign last_entry_c = (rom_addr == {ROM_AW{1'b1}});
  assign cur_byte_c   = byte_of(byte_idx, reg_q, val_q);

  // Sequencer FSM with registered bus and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rom_addr <= '0;
      qcnt     <= '0;
      quarter  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      dly_cnt  <= '0;
      reg_q    <= '0;
      val_q    <= '0;
      sioc     <= 1'b1;
      siod_out <= 1'b1;
      siod_oe  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      qcnt <= tick_c ? '0 : qcnt + QW'(1);

      case (state)
        S_IDLE: begin
          qcnt <= '0;
          if (start) begin
            done     <= 1'b0;
            busy     <= 1'b1;
            rom_addr <= '0;
            state    <= S_FETCH;
          end
        end

        S_FETCH: begin
          qcnt  <= '0;
          state <= S_DECODE;
        end

        S_DECODE: begin
          qcnt     <= '0;
          quarter  <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
          dly_cnt  <= '0;
          if (rom_data == END_WORD) begin
            state <= S_FINISH;
          end else if (rom_data == DLY_WORD) begin
            state <= S_DELAY;
          end else begin
            reg_q                       <= rom_data[15:8];
            val_q                       <= rom_data[7:0];
            {sioc, siod_out, siod_oe}   <= bus_level(S_START, 2'd0, 4'd0, 8'd0);
            state                       <= S_START;
          end
        end

        S_START: begin
          if (tick_c) begin
            if (quarter == 2'd1) begin
              quarter                   <= '0;
              {sioc, siod_out, siod_oe} <= bus_level(S_BYTE, 2'd0, 4'd0, DEV_ID);
              state                     <= S_BYTE;
            end else begin
              quarter                   <= quarter + 2'd1;
              {sioc, siod_out, siod_oe} <= bus_level(S_START, quarter + 2'd1, 4'd0, 8'd0);
            end
          end
        end

        S_BYTE: begin
          if (tick_c) begin
            if (quarter != 2'd3) begin
              quarter                   <= quarter + 2'd1;
              {sioc, siod_out, siod_oe} <= bus_level(S_BYTE, quarter + 2'd1, bit_idx, cur_byte_c);
            end else begin
              quarter <= '0;
              if (bit_idx != 4'd8) begin
                bit_idx                   <= bit_idx + 4'd1;
                {sioc, siod_out, siod_oe} <= bus_level(S_BYTE, 2'd0, bit_idx + 4'd1, cur_byte_c);
              end else if (byte_idx != 2'd2) begin
                bit_idx                   <= '0;
                byte_idx                  <= byte_idx + 2'd1;
                {sioc, siod_out, siod_oe} <= bus_level(S_BYTE, 2'd0, 4'd0,
                                                       byte_of(byte_idx + 2'd1, reg_q, val_q));
              end else begin
                bit_idx                   <= '0;
                byte_idx                  <= '0;
                {sioc, siod_out, siod_oe} <= bus_level(S_STOP, 2'd0, 4'd0, 8'd0);
                state                     <= S_STOP;
              end
            end
          end
        end

        S_STOP: begin
          if (tick_c) begin
            if (quarter == 2'd2) begin
              quarter                   <= '0;
              {sioc, siod_out, siod_oe} <= BUS_IDLE;
              state                     <= S_GAP;
            end else begin
              quarter                   <= quarter + 2'd1;
              {sioc, siod_out, siod_oe} <= bus_level(S_STOP, quarter + 2'd1, 4'd0, 8'd0);
            end
          end
        end

        S_GAP: begin
          if (tick_c) begin
            if (quarter == 2'd3) begin
              quarter <= '0;
              // The last table slot ends the run instead of wrapping the address.
              if (last_entry_c) begin
                state <= S_FINISH;
              end else begin
                rom_addr <= rom_addr + ROM_AW'(1);
                state    <= S_FETCH;
              end
            end else begin
              quarter <= quarter + 2'd1;
            end
          end
        end

        S_DELAY: begin
          qcnt <= '0;
          if (dly_cnt == DLAST) begin
            dly_cnt <= '0;
            if (last_entry_c) begin
              state <= S_FINISH;
            end else begin
              rom_addr <= rom_addr + ROM_AW'(1);
              state    <= S_FETCH;
            end
          end else begin
            dly_cnt <= dly_cnt + DW'(1);
          end
        end

        S_FINISH: begin
          qcnt  <= '0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          qcnt                      <= '0;
          {sioc, siod_out, siod_oe} <= BUS_IDLE;
          state                     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_config_seq.sv
// tb_sccb_config_seq: directed bench for the SCCB configuration sequencer.
// A bus monitor decodes SIOD on SIOC rising edges and records writes,
// ACK-slot drive releases, address steps and busy/done timing.
module tb_sccb_config_seq;

  localparam int unsigned Q   = 4;
  localparam int unsigned DLY = 20;
  localparam int unsigned AW  = 2;
  localparam int unsigned WR  = 117 * Q + 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          sioc;
  logic          siod_out;
  logic          siod_oe;
  logic          busy;
  logic          done;

  logic [15:0]   rom [4];

  int            n_total = 0;
  int            n_bad   = 0;
  int unsigned   cyc     = 0;

  logic          prev_sioc = 1'b1;
  logic          prev_siod = 1'b1;
  logic          prev_oe   = 1'b1;
  logic          prev_busy = 1'b0;
  logic          prev_done = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic          in_frame  = 1'b0;
  logic          start_seen = 1'b0;
  int            nbits     = 0;
  logic [23:0]   wdata     = '0;
  int            n_starts  = 0;
  int            frame_err = 0;
  int            ack_err   = 0;
  int            oe_low    = 0;
  int unsigned   t_busy    = 0;
  int unsigned   t_done    = 0;
  int unsigned   t_start   = 0;

  logic [23:0]   writes [$];
  int            oe_runs [$];
  logic [AW-1:0] addr_log [$];

  sccb_config_seq #(
    .CLK_DIV     (Q),
    .DEV_ID      (8'h42),
    .DELAY_CYCLES(DLY),
    .ROM_AW      (AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .sioc    (sioc),
    .siod_out(siod_out),
    .siod_oe (siod_oe),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Table memory with one cycle of read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Cycle counter used for latency measurements.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor sampling on the falling edge, away from output updates.
  initial forever begin
    @(negedge clk);
    if (busy && !prev_busy) t_busy = cyc;
    if (done && !prev_done) t_done = cyc;
    if (rom_addr != prev_addr) addr_log.push_back(rom_addr);
    if (prev_sioc && sioc && prev_siod && !siod_out) begin
      n_starts++;
      in_frame = 1'b1;
      nbits    = 0;
      wdata    = '0;
      if (!start_seen) begin
        start_seen = 1'b1;
        t_start    = cyc;
      end
    end else if (prev_sioc && sioc && !prev_siod && siod_out) begin
      if (in_frame) begin
        if (nbits == 27) writes.push_back(wdata);
        else frame_err++;
      end
      in_frame = 1'b0;
    end else if (!prev_sioc && sioc && in_frame && nbits < 27) begin
      if (nbits % 9 == 8) begin
        if (siod_oe !== 1'b0) ack_err++;
      end else begin
        if (siod_oe !== 1'b1) ack_err++;
        wdata = {wdata[22:0], siod_out};
      end
      nbits++;
    end
    if (!siod_oe) begin
      oe_low++;
    end else if (!prev_oe) begin
      oe_runs.push_back(oe_low);
      oe_low = 0;
    end
    prev_sioc = sioc;
    prev_siod = siod_out;
    prev_oe   = siod_oe;
    prev_busy = busy;
    prev_done = done;
    prev_addr = rom_addr;
  end

  task automatic clear_logs();
    writes.delete();
    oe_runs.delete();
    addr_log.delete();
    n_starts   = 0;
    frame_err  = 0;
    ack_err    = 0;
    start_seen = 1'b0;
    t_busy     = 0;
    t_done     = 0;
    t_start    = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned limit);
    int unsigned n;
    n = 0;
    while (!done && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(done), 32'd1);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [23:0] get_write(input int i);
    return (i < writes.size()) ? writes[i] : 24'hFFFFFF;
  endfunction

  function automatic int bad_runs();
    int b;
    b = 0;
    foreach (oe_runs[i]) if (oe_runs[i] != int'(4 * Q)) b++;
    return b;
  endfunction

  // {log length, last four addresses as nibbles}
  function automatic logic [31:0] pack_log();
    logic [15:0] p;
    p = '0;
    foreach (addr_log[i]) p = {p[11:0], 4'(addr_log[i])};
    return {16'(addr_log.size()), p};
  endfunction

  initial begin
    rom = '{16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_bus", 32'({sioc, siod_out, siod_oe}), 32'b111);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write followed by the end sentinel.
    clear_logs();
    pulse_start();
    chk("t1_busy_rise", 32'(busy), 32'd1);
    wait_done("t1_done_seen", 3000);
    chk("t1_latency", 32'(t_done - t_busy), 32'(WR + 3));
    chk("t1_start_at", 32'(t_start - t_busy), 32'd2);
    chk("t1_nwrites", 32'(writes.size()), 32'd1);
    chk("t1_write0", 32'(get_write(0)), 32'h421280);
    chk("t1_oe_runs", 32'(oe_runs.size()), 32'd3);
    chk("t1_oe_len", 32'(bad_runs()), 32'd0);
    chk("t1_ack_oe", 32'(ack_err), 32'd0);
    chk("t1_frames", 32'(frame_err), 32'd0);
    chk("t1_addr_log", pack_log(), 32'h0001_0001);
    chk("t1_busy_low", 32'(busy), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("t1_done_hold", 32'(done), 32'd1);
    chk("t1_idle_bus", 32'({sioc, siod_out, siod_oe}), 32'b111);

    // Delay entry, one write, end sentinel.
    rom = '{16'hFFF0, 16'h1100, 16'hFFFF, 16'hFFFF};
    clear_logs();
    pulse_start();
    chk("t2_done_clr", 32'(done), 32'd0);
    wait_done("t2_done_seen", 3000);
    chk("t2_start_at", 32'(t_start - t_busy), 32'(DLY + 4));
    chk("t2_latency", 32'(t_done - t_busy), 32'(DLY + 2 + WR + 3));
    chk("t2_nwrites", 32'(writes.size()), 32'd1);
    chk("t2_write0", 32'(get_write(0)), 32'h421100);
    chk("t2_oe_runs", 32'(oe_runs.size()), 32'd3);
    chk("t2_oe_len", 32'(bad_runs()), 32'd0);
    chk("t2_addr_log", pack_log(), 32'h0003_0012);

    // Second start while busy must be ignored.
    rom = '{16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    clear_logs();
    pulse_start();
    repeat (50) @(posedge clk);
    pulse_start();
    wait_done("t3_done_seen", 3000);
    chk("t3_latency", 32'(t_done - t_busy), 32'(WR + 3));
    chk("t3_nstarts", 32'(n_starts), 32'd1);
    chk("t3_write0", 32'(get_write(0)), 32'h421280);
    chk("t3_addr_log", pack_log(), 32'h0002_0001);

    // Asynchronous reset during the register byte, then a fresh run.
    clear_logs();
    pulse_start();
    repeat (171) @(posedge clk);
    #2;
    chk("t4_pre_sioc", 32'(sioc), 32'd0);
    chk("t4_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_bus", 32'({sioc, siod_out, siod_oe}), 32'b111);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_done", 32'(done), 32'd0);
    chk("t4_rst_addr", 32'(rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    pulse_start();
    wait_done("t4_done_seen", 3000);
    chk("t4_latency", 32'(t_done - t_busy), 32'(WR + 3));
    chk("t4_nwrites", 32'(writes.size()), 32'd1);
    chk("t4_write0", 32'(get_write(0)), 32'h421280);
    chk("t4_addr_log", pack_log(), 32'h0001_0001);

    // Full table without sentinel: ends at the last address.
    rom = '{16'h1280, 16'h1100, 16'h3A04, 16'h40D0};
    clear_logs();
    pulse_start();
    wait_done("t5_done_seen", 3000);
    chk("t5_latency", 32'(t_done - t_busy), 32'(4 * WR + 1));
    chk("t5_nwrites", 32'(writes.size()), 32'd4);
    chk("t5_write0", 32'(get_write(0)), 32'h421280);
    chk("t5_write1", 32'(get_write(1)), 32'h421100);
    chk("t5_write2", 32'(get_write(2)), 32'h423A04);
    chk("t5_write3", 32'(get_write(3)), 32'h4240D0);
    chk("t5_oe_runs", 32'(oe_runs.size()), 32'd12);
    chk("t5_oe_len", 32'(bad_runs()), 32'd0);
    chk("t5_ack_oe", 32'(ack_err), 32'd0);
    chk("t5_frames", 32'(frame_err), 32'd0);
    chk("t5_addr_end", 32'(rom_addr), 32'd3);
    chk("t5_addr_log", pack_log(), 32'h0004_0123);
    chk("t5_busy_low", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
